sc_nonoverlap_phase_gen: RTL

//  Generates the non-overlapping two-phase switch clocks (phi1/phi2) that drive the switched-capacitor

---
 rtl/sc_phase_pkg.sv | 6 +
 rtl/sc_rr_channel_sel.sv | 23 ++
 rtl/sc_nonoverlap_phase_gen.sv | 115 +++++++++++
 3 files changed

// File: rtl/sc_phase_pkg.sv
// sc_phase_pkg: FSM state encoding and minimum phase/dead-time constants for the phase generator
package sc_phase_pkg;
  typedef enum logic [2:0] {IDLE, P1, GAP12, P2, GAP21} state_e;
  localparam int MIN_PHASE = 2;
  localparam int MIN_DEAD = 1;
endpackage

// File: rtl/sc_rr_channel_sel.sv
// sc_rr_channel_sel: finds the next enabled channel after ptr (ascending, wrapping)
// ptr/ch_en in; next_ptr is ptr itself when no channel is enabled; any_en = |ch_en
module sc_rr_channel_sel #(
  parameter int NUM_CH = 4,
  parameter int PW = 2
) (
  input  logic [PW-1:0]     ptr,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [PW-1:0]     next_ptr,
  output logic              any_en
);
  logic [PW-1:0] idx;
  always_comb begin
    any_en = |ch_en;
    next_ptr = ptr;
    idx = ptr;
    // scan farthest-first so the nearest enabled channel is assigned last
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % NUM_CH);
      if (ch_en[idx]) next_ptr = idx;
    end
  end
endmodule

// File: rtl/sc_nonoverlap_phase_gen.sv
// sc_nonoverlap_phase_gen: non-overlapping phi1/phi1e/phi2 switch clocks for NUM_CH SC channels
// in: clk, rst_n (async low), en, mode_il, ch_en, phase_cfg, dead_cfg
// out: phi1, phi1e, phi2 (per channel, registered), busy, period_done
module sc_nonoverlap_phase_gen
  import sc_phase_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W = 8,
  parameter int DEAD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode_il,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [DIV_W-1:0]  phase_cfg,
  input  logic [DEAD_W-1:0] dead_cfg,
  output logic [NUM_CH-1:0] phi1,
  output logic [NUM_CH-1:0] phi1e,
  output logic [NUM_CH-1:0] phi2,
  output logic              busy,
  output logic              period_done
);
  localparam int CW = DIV_W > DEAD_W ? DIV_W : DEAD_W;
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, phase_q, phase_d, dead_q, dead_d, phase_in, dead_in;
  logic [NUM_CH-1:0] mask_q, mask_d, phi1_d, phi1e_d, phi2_d;
  logic [PW-1:0] ptr_q, ptr_d, nxt_ptr, ptr_go;
  logic mode_q, mode_d, busy_d, done_d, any_en, last, start;
  sc_rr_channel_sel #(.NUM_CH(NUM_CH), .PW(PW)) u_sel (
    .ptr(ptr_q), .ch_en(ch_en), .next_ptr(nxt_ptr), .any_en(any_en)
  );
  always_comb begin
    phase_in = phase_cfg < DIV_W'(MIN_PHASE) ? CW'(MIN_PHASE) : CW'(phase_cfg);
    dead_in = dead_cfg < DEAD_W'(MIN_DEAD) ? CW'(MIN_DEAD) : CW'(dead_cfg);
    last = cnt_q == CW'(1);
    start = en && any_en;
    // rotate after an interleaved period, and never start on a disabled pointer
    ptr_go = ((state_q == GAP21 && mode_q) || !ch_en[ptr_q]) ? nxt_ptr : ptr_q;
    state_d = state_q;
    cnt_d = state_q == IDLE ? '0 : cnt_q - CW'(1);
    phase_d = phase_q;
    dead_d = dead_q;
    mask_d = mask_q;
    mode_d = mode_q;
    ptr_d = ptr_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = P1;
        ptr_d = ptr_go;
      end
      P1: if (last) begin
        state_d = GAP12;
        cnt_d = dead_q;
      end
      GAP12: if (last) begin
        state_d = P2;
        cnt_d = phase_q;
      end
      P2: if (last) begin
        state_d = GAP21;
        cnt_d = dead_q;
      end
      GAP21: if (last) begin
        state_d = start ? P1 : IDLE;
        ptr_d = ptr_go;
      end
      default: state_d = IDLE;
    endcase
    // config, channel set and mode are frozen for the whole period on entry to P1
    if (state_d == P1 && state_q != P1) begin
      phase_d = phase_in;
      dead_d = dead_in;
      cnt_d = phase_in;
      mode_d = mode_il;
      mask_d = mode_il ? NUM_CH'(1) << ptr_d : ch_en;
    end
    if (state_d == IDLE) cnt_d = '0;
    phi1_d = state_d == P1 ? mask_d : '0;
    phi1e_d = (state_d == P1 && cnt_d != CW'(1)) ? mask_d : '0;
    phi2_d = state_d == P2 ? mask_d : '0;
    busy_d = state_d != IDLE;
    done_d = state_d == GAP21 && cnt_d == CW'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      phase_q <= '0;
      dead_q <= '0;
      mask_q <= '0;
      mode_q <= 1'b0;
      ptr_q <= '0;
      phi1 <= '0;
      phi1e <= '0;
      phi2 <= '0;
      busy <= 1'b0;
      period_done <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      dead_q <= dead_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
      ptr_q <= ptr_d;
      phi1 <= phi1_d;
      phi1e <= phi1e_d;
      phi2 <= phi2_d;
      busy <= busy_d;
      period_done <= done_d;
    end
  end
endmodule
